// File: rtl/morph3x3_filter.sv
// Streaming 3x3 binary dilation/erosion over N independent bit planes.
// Two rows live in one prefetched line-buffer RAM; borders are padded with the neutral value.
`timescale 1ns/1ps
module morph3x3_filter #(
    parameter int N         = 1,
    parameter int MAX_WIDTH = 1024,
    parameter int WW        = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [WW-1:0] width,
    input  logic [WW-1:0] height,
    input  logic          mode,
    input  logic [8:0]    mask,
    input  logic          in_write,
    input  logic [N-1:0]  in_pixel,
    output logic          out_read,
    output logic [N-1:0]  out_pixel,
    output logic          busy,
    output logic          frame_done,
    output logic          cfg_err
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [WW:0] MAX_W = (WW+1)'(MAX_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state_reg, state_next;

    logic [WW-1:0]    w_reg, h_reg, col_reg, row_reg, cen_col_reg, cen_row_reg;
    logic [AW-1:0]    addr_reg, next_addr, rd_addr;
    logic             mode_reg, primed_reg;
    logic [8:0]       mask_reg, tap_ok;
    logic [2:0][N-1:0] left_reg, mid_reg, new_col;
    logic [2*N-1:0]   line_mem [MAX_WIDTH];
    logic [2*N-1:0]   line_rd_reg;

    logic          cfg_ok, start, wr_fire, emit, col_last, row_last, last_in, flush_end;
    logic [WW-1:0] eff_w, next_col;
    logic [N-1:0]  wr_pix, result;
    logic [N-1:0]  win [9];

    always_comb begin
        cfg_ok    = (width >= WW'(2)) && ({1'b0, width} <= MAX_W) && (height >= WW'(2));
        start     = (state_reg == IDLE) && in_write && cfg_ok;
        // FLUSH injects zero pixels so the trailing outputs drain; bottom padding masks them.
        wr_fire   = start || ((state_reg == RUN) && in_write) || (state_reg == FLUSH);
        emit      = wr_fire && primed_reg;
        eff_w     = (state_reg == IDLE) ? width : w_reg;
        col_last  = (col_reg == eff_w - WW'(1));
        row_last  = (row_reg == h_reg - WW'(1));
        next_col  = col_last ? '0 : col_reg + WW'(1);
        next_addr = col_last ? '0 : addr_reg + AW'(1);
        // Prefetch the column that the next write will need, so read data is ready in time.
        rd_addr   = wr_fire ? next_addr : addr_reg;
        wr_pix    = (state_reg == FLUSH) ? '0 : in_pixel;
        last_in   = (state_reg == RUN) && in_write && row_last && col_last;
        flush_end = (state_reg == FLUSH) && (row_reg == WW'(1)) && (col_reg == '0);
        new_col[0] = line_rd_reg[2*N-1:N];
        new_col[1] = line_rd_reg[N-1:0];
        new_col[2] = wr_pix;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start)     state_next = RUN;
            RUN:     if (last_in)   state_next = FLUSH;
            FLUSH:   if (flush_end) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            tap_ok[k] = mask_reg[k]
                && !((k < 3)      && (cen_row_reg == '0))
                && !((k >= 6)     && (cen_row_reg == h_reg - WW'(1)))
                && !((k % 3 == 0) && (cen_col_reg == '0))
                && !((k % 3 == 2) && (cen_col_reg == w_reg - WW'(1)));
        end
    end

    for (genvar gi = 0; gi < 9; gi++) begin : g_tap
        localparam int R = gi / 3;
        localparam int C = gi % 3;
        if (C == 0) begin : g_left
            assign win[gi] = left_reg[R];
        end else if (C == 1) begin : g_mid
            assign win[gi] = mid_reg[R];
        end else begin : g_right
            assign win[gi] = new_col[R];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_plane
        logic [8:0] bits;
        always_comb begin
            for (int k = 0; k < 9; k++) bits[k] = win[k][gi];
        end
        assign result[gi] = mode_reg ? &(bits | ~tap_ok) : |(bits & tap_ok);
    end

    // Each entry holds {row r-1, row r} for its column.
    always_ff @(posedge clock) begin
        if (wr_fire) line_mem[addr_reg] <= {new_col[1], wr_pix};
        line_rd_reg <= line_mem[rd_addr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            w_reg       <= '0;
            h_reg       <= '0;
            mode_reg    <= 1'b0;
            mask_reg    <= '0;
            col_reg     <= '0;
            row_reg     <= '0;
            addr_reg    <= '0;
            cen_col_reg <= '0;
            cen_row_reg <= '0;
            primed_reg  <= 1'b0;
            left_reg    <= '0;
            mid_reg     <= '0;
            out_read    <= 1'b0;
            out_pixel   <= '0;
            frame_done  <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            out_read   <= emit;
            frame_done <= emit && flush_end;
            cfg_err    <= (state_reg == IDLE) && in_write && !cfg_ok;
            if (emit) out_pixel <= result;
            if (start) begin
                w_reg    <= width;
                h_reg    <= height;
                mode_reg <= mode;
                mask_reg <= mask;
            end
            if (flush_end) begin
                col_reg     <= '0;
                row_reg     <= '0;
                addr_reg    <= '0;
                cen_col_reg <= '0;
                cen_row_reg <= '0;
                primed_reg  <= 1'b0;
            end else if (wr_fire) begin
                col_reg  <= next_col;
                addr_reg <= next_addr;
                if (col_last) row_reg <= row_last ? '0 : row_reg + WW'(1);
                // Outputs begin with the write after pixel (1,0), i.e. W+1 writes in.
                if ((row_reg == WW'(1)) && (col_reg == '0)) primed_reg <= 1'b1;
                left_reg <= mid_reg;
                mid_reg  <= new_col;
                if (emit) begin
                    if (cen_col_reg == w_reg - WW'(1)) begin
                        cen_col_reg <= '0;
                        cen_row_reg <= (cen_row_reg == h_reg - WW'(1)) ? '0 : cen_row_reg + WW'(1);
                    end else begin
                        cen_col_reg <= cen_col_reg + WW'(1);
                    end
                end
            end
        end
    end

    assign busy = (state_reg == FLUSH);

endmodule

// File: tb/tb_morph3x3_filter.sv
// Randomized scoreboard bench for morph3x3_filter: a direct-neighbourhood reference model
// predicts every output; a forked monitor pops and compares as outputs appear.
`timescale 1ns/1ps
module tb_morph3x3_filter;
    localparam int N = 2;
    localparam int MAXW = 16;
    localparam int WW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [WW-1:0] width = '0, height = '0;
    logic          mode = 1'b0;
    logic [8:0]    mask = '0;
    logic          in_write = 1'b0;
    logic [N-1:0]  in_pixel = '0;
    logic          out_read, busy, frame_done, cfg_err;
    logic [N-1:0]  out_pixel;

    morph3x3_filter #(.N(N), .MAX_WIDTH(MAXW), .WW(WW)) dut (
        .clock(clock), .reset_n(reset_n), .width(width), .height(height),
        .mode(mode), .mask(mask), .in_write(in_write), .in_pixel(in_pixel),
        .out_read(out_read), .out_pixel(out_pixel), .busy(busy),
        .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic [N-1:0] pix; bit last; } exp_t;
    exp_t exp_q[$];
    logic [N-1:0] img [256];

    int checks = 0, errors = 0;
    int done_cnt = 0, frame_outs = 0, busy_cycles = 0, cfg_err_cnt = 0, first_out_cyc = 0;

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Neighbourhood of pixel p straight from the image: taps outside the frame are skipped.
    function automatic logic [N-1:0] ref_px(int w, int h, bit m, logic [8:0] mk, int p);
        int r = p / w;
        int c = p % w;
        logic [N-1:0] res;
        for (int n = 0; n < N; n++) begin
            bit acc = m;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    int rr = r + dr;
                    int cc = c + dc;
                    int k = 3 * (dr + 1) + (dc + 1);
                    if (mk[k] && rr >= 0 && rr < h && cc >= 0 && cc < w) begin
                        if (m) acc = acc & img[rr * w + cc][n];
                        else   acc = acc | img[rr * w + cc][n];
                    end
                end
            end
            res[n] = acc;
        end
        return res;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (busy) busy_cycles++;
                if (cfg_err) cfg_err_cnt++;
                if (frame_done && !out_read) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_done_without_out_read at cycle %0d", cyc);
                end
                if (out_read) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0d expected none", int'(out_pixel));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pixel", int'(out_pixel), int'(e.pix));
                        chk("frame_done_flag", int'(frame_done), int'(e.last));
                        if (frame_outs == 0) first_out_cyc = cyc;
                        frame_outs++;
                        if (frame_done) done_cnt++;
                    end
                end
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic write_px(logic [N-1:0] px);
        in_write = 1'b1;
        in_pixel = px;
        @(posedge clock);
        #1;
        in_write = 1'b0;
    endtask

    task automatic run_frame(int w, int h, bit m, logic [8:0] mk, int gap_pct,
                             bit scramble, bit poke, bit timing);
        int d0;
        int wcyc;
        int guard;
        width = WW'(w);
        height = WW'(h);
        mode = m;
        mask = mk;
        frame_outs = 0;
        busy_cycles = 0;
        wcyc = 0;
        for (int p = 0; p < w * h; p++)
            exp_q.push_back('{pix: ref_px(w, h, m, mk, p), last: (p == w * h - 1)});
        d0 = done_cnt;
        for (int i = 0; i < w * h; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) idle(1);
            if (i == 0) wcyc = cyc;
            write_px(img[i]);
            if (i == 0 && scramble) begin
                width = WW'($urandom_range(1, 40));
                height = WW'($urandom_range(0, 9));
                mode = ~m;
                mask = 9'($urandom);
            end
        end
        if (poke) begin
            chk("busy_after_last_write", int'(busy), 1);
            write_px('1);
        end
        guard = 0;
        while (done_cnt == d0 && guard < w + 20) begin
            @(posedge clock);
            #1;
            guard++;
        end
        chk("frame_done_seen", done_cnt - d0, 1);
        chk("outputs_per_frame", frame_outs, w * h);
        if (timing) begin
            chk("first_out_latency", first_out_cyc - wcyc, 5);
            chk("busy_cycles", busy_cycles, w + 1);
        end
        idle(1);
    endtask

    task automatic fill(logic [N-1:0] v);
        for (int i = 0; i < 256; i++) img[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) img[i] = N'($urandom_range(0, 3));
    endtask

    initial begin
        fork
            monitor();
        join_none

        @(negedge clock);
        chk("reset_out_read", int'(out_read), 0);
        chk("reset_out_pixel", int'(out_pixel), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_cfg_err", int'(cfg_err), 0);
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // single dot dilated by full 3x3
        fill('0); img[1 * 4 + 1] = '1;
        run_frame(4, 3, 1'b0, 9'h1FF, 0, 1'b0, 1'b0, 1'b0);
        // all-ones erosion: padding must not erode borders
        fill('1);
        run_frame(4, 3, 1'b1, 9'h1FF, 0, 1'b0, 1'b0, 1'b0);
        // corner hole erosion
        fill('1); img[0] = '0;
        run_frame(5, 4, 1'b1, 9'h1FF, 0, 1'b0, 1'b0, 1'b0);
        // cross at right edge: nothing may wrap into the next row
        fill('0); img[3] = '1;
        run_frame(4, 4, 1'b0, 9'h0BA, 0, 1'b0, 1'b0, 1'b0);
        // smallest frame: latency, busy length, dropped write during flush
        fill_rand();
        run_frame(3, 2, 1'($urandom_range(0, 1)), 9'($urandom), 0, 1'b0, 1'b1, 1'b1);

        // rejected configurations
        width = 1; height = 3;
        write_px(2'b01);
        chk("cfg_err_width1", int'(cfg_err), 1);
        idle(1);
        chk("cfg_err_clears", int'(cfg_err), 0);
        chk("busy_after_cfg_err", int'(busy), 0);
        width = WW'(MAXW + 1); height = 3;
        write_px(2'b01);
        chk("cfg_err_too_wide", int'(cfg_err), 1);
        width = 4; height = 1;
        write_px(2'b01);
        chk("cfg_err_height1", int'(cfg_err), 1);
        idle(2);

        // reset mid-frame after six writes (one output already due)
        fill('0); img[1 * 4 + 1] = '1;
        width = 4; height = 3; mode = 1'b0; mask = 9'h1FF;
        frame_outs = 0;
        exp_q.push_back('{pix: ref_px(4, 3, 1'b0, 9'h1FF, 0), last: 1'b0});
        for (int i = 0; i < 6; i++) write_px(img[i]);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset_out_read", int'(out_read), 0);
        chk("midreset_frame_done", int'(frame_done), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_outputs_before", frame_outs, 1);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        run_frame(4, 3, 1'b0, 9'h1FF, 0, 1'b0, 1'b0, 1'b0);

        // widest frame
        fill_rand();
        run_frame(MAXW, 2, 1'($urandom_range(0, 1)), 9'($urandom), 0, 1'b0, 1'b0, 1'b0);

        // random frames with gaps and port churn during the frame
        for (int f = 0; f < 14; f++) begin
            fill_rand();
            run_frame(int'($urandom_range(2, 10)), int'($urandom_range(2, 6)),
                      1'($urandom_range(0, 1)), 9'($urandom),
                      (f % 2 == 0) ? 30 : 0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end

        chk("cfg_err_pulses", cfg_err_cnt, 3);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
